// File: rtl/tinker_pkg.sv
// Shared types and constants for the Tinker instruction-fetch stage.
package tinker_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h2000;
  localparam int unsigned INSTR_BYTES      = 4;

  typedef enum logic {
    RUN,
    FAULT
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched instructions with their PCs; flush wins over push.
module fetch_fifo
  import tinker_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  fetch_entry_t  push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output fetch_entry_t  head
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (rst_n && !flush && push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !flush && (count == CW'(DEPTH))));

endmodule

// File: rtl/tinker_fetch.sv
// Tinker fetch stage: PC sequencing, credit-limited imem requests, response buffering and redirects.
module tinker_fetch
  import tinker_pkg::*;
#(
  parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned MEM_SIZE = 524288,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [63:0] dec_pc,
  output logic        fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned SW = CW + 1;

  fetch_state_t  state;
  logic [63:0]   pc;
  logic [63:0]   rsp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [CW-1:0] fifo_count;

  logic          pc_ok;
  logic          credit;
  logic          req_fire;
  logic          redirect_take;
  logic          rsp_keep;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;

  // Limit check done in 65 bits so a PC near 2^64 cannot wrap into range.
  assign pc_ok = (pc[1:0] == 2'b00) &&
                 (({1'b0, pc} + 65'(INSTR_BYTES)) <= 65'(MEM_SIZE));

  assign credit = (SW'(fifo_count) + SW'(outstanding)) < SW'(DEPTH);

  assign imem_req_valid = rst_n && (state == RUN) && !redirect_valid && credit && pc_ok;
  assign imem_req_addr  = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign redirect_take = redirect_valid && (state == RUN);
  assign rsp_keep      = imem_rsp_valid && (drop_cnt == '0) && !redirect_take;

  assign dec_valid = rst_n && (fifo_count != '0);
  assign dec_instr = head.instr;
  assign dec_pc    = head.pc;
  assign pop       = dec_valid && dec_ready;
  assign fault     = (state == FAULT);

  assign push_entry = '{instr: imem_rsp_data, pc: rsp_pc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= RUN;
      pc          <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_take) begin
        // Everything still in flight, minus a response landing now, is stale.
        pc       <= redirect_pc;
        rsp_pc   <= redirect_pc;
        drop_cnt <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          pc <= pc + 64'(INSTR_BYTES);
        end
        if (rsp_keep) begin
          rsp_pc <= rsp_pc + 64'(INSTR_BYTES);
        end
        if (imem_rsp_valid && (drop_cnt != '0)) begin
          drop_cnt <= drop_cnt - 1'b1;
        end
        if ((state == RUN) && !redirect_valid && !pc_ok) begin
          state <= FAULT;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_take),
    .count     (fifo_count),
    .head      (head)
  );

  a_rsp_has_owner: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && (outstanding == '0)));

endmodule
